// File: rtl/fp_bandpass_fir_pkg.sv
// fp_bandpass_fir_pkg: fp32 constants and round-to-nearest-even, flush-to-zero multiply/add helpers
package fp_bandpass_fir_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS = 127;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN = 32'h7fc0_0000;

  // e is the biased exponent before rounding; a mantissa carry-out bumps it
  function automatic logic [31:0] fp32_pack(input logic s, input int e, input logic [23:0] m,
                                            input logic g, input logic st);
    logic [24:0] r;
    int ee;
    ee = e;
    r = {1'b0, m} + 25'(g & (st | m[0]));
    if (r[24]) begin
      ee = ee + 1;
      r = r >> 1;
    end
    return ee >= 255 ? {s, 8'hff, 23'h0} : ee <= 0 ? {s, 31'h0} : {s, 8'(ee), r[MAN_W-1:0]};
  endfunction

  function automatic logic [31:0] fp32_mul(input logic [31:0] a, input logic [31:0] b);
    logic s, az, bz, ai, bi, an, bn;
    logic [47:0] p;
    int e;
    s = a[31] ^ b[31];
    az = a[30:23] == 8'h00;
    bz = b[30:23] == 8'h00;
    ai = a[30:23] == 8'hff && a[22:0] == 23'h0;
    bi = b[30:23] == 8'hff && b[22:0] == 23'h0;
    an = a[30:23] == 8'hff && a[22:0] != 23'h0;
    bn = b[30:23] == 8'hff && b[22:0] != 23'h0;
    if (an || bn || (ai && bz) || (bi && az)) return FP_QNAN;
    if (ai || bi) return {s, 8'hff, 23'h0};
    if (az || bz) return {s, 31'h0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - BIAS;
    if (p[47]) return fp32_pack(s, e + 1, p[47:24], p[23], |p[22:0]);
    return fp32_pack(s, e, p[46:23], p[22], |p[21:0]);
  endfunction

  // 26 spare bits below the mantissa keep the aligned addend exact up to a
  // 26-bit shift; anything shifted further collapses into a sticky LSB
  function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
    logic az, bz, ai, bi, an, bn;
    logic [31:0] l, t;
    logic [49:0] ml, ms;
    logic [50:0] sm;
    int d, lz;
    az = a[30:23] == 8'h00;
    bz = b[30:23] == 8'h00;
    ai = a[30:23] == 8'hff && a[22:0] == 23'h0;
    bi = b[30:23] == 8'hff && b[22:0] == 23'h0;
    an = a[30:23] == 8'hff && a[22:0] != 23'h0;
    bn = b[30:23] == 8'hff && b[22:0] != 23'h0;
    if (an || bn || (ai && bi && a[31] != b[31])) return FP_QNAN;
    if (ai) return a;
    if (bi) return b;
    if (az && bz) return {a[31] & b[31], 31'h0};
    if (az) return b;
    if (bz) return a;
    {l, t} = a[30:0] >= b[30:0] ? {a, b} : {b, a};
    d = int'(l[30:23]) - int'(t[30:23]);
    ml = {1'b1, l[22:0], 26'h0};
    ms = {1'b1, t[22:0], 26'h0};
    ms = d > 49 ? 50'h1 : (ms >> d) | 50'(|(ms & ((50'h1 << d) - 50'h1)));
    sm = l[31] == t[31] ? {1'b0, ml} + {1'b0, ms} : {1'b0, ml} - {1'b0, ms};
    if (sm == 51'h0) return FP_ZERO;
    lz = 0;
    for (int i = 0; i < 51; i++) if (sm[i]) lz = 50 - i;
    sm = sm << lz;
    return fp32_pack(l[31], int'(l[30:23]) + 1 - lz, sm[50:27], sm[26], |sm[25:0]);
  endfunction
endpackage

// File: rtl/fp_bandpass_fir_mac.sv
// fp32_mac: combinational acc_out = acc_in + a*b with separately rounded multiply and add
module fp32_mac
  import fp_bandpass_fir_pkg::*;
(
  input  logic [31:0] acc_in,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] acc_out
);
  assign acc_out = fp32_add(acc_in, fp32_mul(a, b));
endmodule

// File: rtl/fp_bandpass_fir.sv
// fp_bandpass_fir: streaming fp32 direct-form FIR, one registered output per accepted sample
module fp_bandpass_fir
  import fp_bandpass_fir_pkg::*;
#(
  parameter int TAP_CNT = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] data_in,
  output logic        valid_out,
  output logic [31:0] data_out
);
  reg   [31:0] coeffs [0:TAP_CNT-1];
  logic [31:0] x      [0:TAP_CNT-1];
  logic [31:0] xp     [0:TAP_CNT-1];
  logic [31:0] acc    [0:TAP_CNT];

  assign acc[0] = FP_ZERO;

  // xp is the delay line as it will look after accepting data_in
  for (genvar k = 0; k < TAP_CNT; k++) begin : g_tap
    if (k == 0) begin : g_head
      assign xp[k] = data_in;
    end else begin : g_tail
      assign xp[k] = x[k-1];
    end
    fp32_mac u_mac (
      .acc_in (acc[k]),
      .a      (coeffs[k]),
      .b      (xp[k]),
      .acc_out(acc[k+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAP_CNT; i++) x[i] <= FP_ZERO;
      valid_out <= 1'b0;
      data_out  <= FP_ZERO;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        x        <= xp;
        data_out <= acc[TAP_CNT];
      end
    end
  end
endmodule

// File: tb/tb_fp_bandpass_fir.sv
// tb_fp_bandpass_fir: directed vectors against a real-arithmetic reference model of the fp32 FIR
module tb_fp_bandpass_fir;
  localparam int N = 31;
  localparam logic [31:0] QNAN = 32'h7fc0_0000;
  localparam logic [31:0] C [0:N-1] = '{
    32'hbb306eeb, 32'hbb75b0a5, 32'hbbbb295a, 32'hbbf41e6a, 32'hbc1a7d2c, 32'hbc2f9b71,
    32'hbc2a0c4e, 32'hbbf3e1a2, 32'h3b0c61f0, 32'h3c4b1e8d, 32'h3cd0a3f7, 32'h3d2481c6,
    32'h3d6a0f93, 32'h3d96d2b4, 32'h3daa4e31, 32'h3db43958, 32'h3daa4e31, 32'h3d96d2b4,
    32'h3d6a0f93, 32'h3d2481c6, 32'h3cd0a3f7, 32'h3c4b1e8d, 32'h3b0c61f0, 32'hbbf3e1a2,
    32'hbc2a0c4e, 32'hbc2f9b71, 32'hbc1a7d2c, 32'hbbf41e6a, 32'hbbbb295a, 32'hbb75b0a5,
    32'hbb306eeb};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic        valid_out;
  logic [31:0] data_out;

  fp_bandpass_fir #(.TAP_CNT(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .data_in  (data_in),
    .valid_out(valid_out),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < N; i++) dut.coeffs[i] = C[i];

  int          n_vec = 0;
  int          n_bad = 0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_data = 32'h0;
  logic [31:0] last_y;
  logic [31:0] hist [0:N-1];
  logic [31:0] y_m [0:N-1];
  logic [31:0] y_d [0:N-1];

  // fp32 -> double is exact; subnormals read as signed zero
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'h00) d = {f[31], 63'h0};
    else if (f[30:23] == 8'hff) d = {f[31], 11'h7ff, f[22:0], 29'h0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  // double -> fp32 with round-to-nearest-even, overflow to inf, tiny to signed zero
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [24:0] m;
    int e;
    d = $realtobits(r);
    if (d[62:52] == 11'h7ff) return d[51:0] != 52'h0 ? QNAN : {d[63], 8'hff, 23'h0};
    if (d[62:52] == 11'h0) return {d[63], 31'h0};
    e = int'(d[62:52]) - 1023;
    m = {2'b01, d[51:29]};
    if (d[28] && (d[27:0] != 28'h0 || d[29])) m = m + 25'd1;
    if (m[24]) begin
      e = e + 1;
      m = m >> 1;
    end
    if (e > 127) return {d[63], 8'hff, 23'h0};
    if (e < -126) return {d[63], 31'h0};
    return {d[63], 8'(e + 127), m[22:0]};
  endfunction

  // a double holds any fp32 product exactly and rounds fp32 sums without double-rounding error
  function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] model_y(input logic [31:0] d);
    logic [31:0] acc;
    acc = 32'h0;
    for (int k = 0; k < N; k++) acc = m_add(acc, m_mul(C[k], k == 0 ? d : hist[k-1]));
    return acc;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    check("valid_out", {31'h0, valid_out}, {31'h0, exp_valid});
    check("data_out", data_out, exp_data);
  end

  task automatic step(input logic v, input logic [31:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    if (v) begin
      last_y = model_y(d);
      exp_data = last_y;
      for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = d;
    end
    exp_valid = v;
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    exp_valid = 1'b0;
    exp_data  = 32'h0;
    for (int k = 0; k < N; k++) hist[k] = 32'h0;
    #1;
    check("rst_valid", {31'h0, valid_out}, 32'h0);
    check("rst_data", data_out, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic impulse(input logic [31:0] amp, input int gap);
    for (int i = 0; i < N; i++) begin
      if (i > 0) repeat (gap) step(1'b0, 32'h0);
      step(1'b1, i == 0 ? amp : 32'h0);
      y_m[i] = last_y;
      y_d[i] = data_out;
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) hist[k] = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_valid", {31'h0, valid_out}, 32'h0);
    check("reset_data", data_out, 32'h0);

    repeat (5) step(1'b1, 32'h0);
    check("zero_data", data_out, 32'h0);
    step(1'b0, 32'h0);
    check("idle_valid", {31'h0, valid_out}, 32'h0);

    do_reset();
    impulse(32'h3f800000, 0);
    check("imp_first", y_d[0], 32'hbb306eeb);
    check("imp_model_first", y_m[0], 32'hbb306eeb);
    check("imp_center", y_d[15], 32'h3db43958);
    check("imp_model_center", y_m[15], 32'h3db43958);
    for (int i = 0; i < N; i++) check("imp_seq", y_d[i], C[i]);

    do_reset();
    impulse(32'h40000000, 0);
    check("scaled_first", y_d[0], 32'hbbb06eeb);
    check("scaled_model_center", y_m[15], 32'h3e343958);
    for (int i = 0; i < N; i++) check("scaled_seq", y_d[i], C[i] + 32'h0080_0000);

    do_reset();
    impulse(32'h3f800000, 2);
    for (int i = 0; i < N; i++) check("gapped_seq", y_d[i], C[i]);

    do_reset();
    repeat (40) step(1'b1, 32'h3f800000);
    step(1'b0, 32'h0);

    repeat (10) step(1'b1, 32'h3f800000);
    do_reset();
    impulse(32'h3f800000, 0);
    for (int i = 0; i < N; i++) check("post_rst_seq", y_d[i], C[i]);

    do_reset();
    step(1'b1, 32'h7f800000);
    check("inf_in", data_out, 32'hff800000);
    step(1'b1, 32'h0);
    check("inf_tap1", data_out, 32'hff800000);
    repeat (6) step(1'b1, 32'h0);
    step(1'b1, 32'h7f800000);
    check("inf_minus_inf", data_out, QNAN);

    do_reset();
    step(1'b1, 32'h7fc00001);
    check("nan_in", data_out, QNAN);

    do_reset();
    step(1'b1, 32'h80400000);
    check("subnormal_in", data_out, 32'h0);
    step(1'b1, 32'h7f7fffff);
    step(1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
